// File: rtl/tt_um_collect_if.sv
// Bit-serial collector bus.
//
// Groups the upstream bit-slice input, the downstream word handshake and the
// sticky status flags of tt_um_collect into one bundle.
//   in_valid       upstream multiplier is in its MULT phase
//   in_bit_select  bit position carried this cycle (0 = LSB)
//   in_bits        one result bit per lane for that position
//   out_ready      downstream accepts out_data this cycle
//   out_valid      out_data / out_index are valid
//   out_data       reassembled result word
//   out_index      lane number of out_data
//   overflow       sticky: a completed frame was dropped (FIFO full)
//   sync_err       sticky: an out-of-sequence bit position was seen
//
// Modports: master = upstream/downstream environment, slave = collector.
`timescale 1ns / 1ps

interface tt_um_collect_if #(
    parameter int unsigned MAX_OUT_LEN = 7,
    parameter int unsigned BIT_WIDTH   = 8
);
    logic                   in_valid;
    logic [2:0]             in_bit_select;
    logic [MAX_OUT_LEN-1:0] in_bits;
    logic                   out_ready;
    logic                   out_valid;
    logic [BIT_WIDTH-1:0]   out_data;
    logic [2:0]             out_index;
    logic                   overflow;
    logic                   sync_err;

    modport master (
        output in_valid,
        output in_bit_select,
        output in_bits,
        output out_ready,
        input  out_valid,
        input  out_data,
        input  out_index,
        input  overflow,
        input  sync_err
    );

    modport slave (
        input  in_valid,
        input  in_bit_select,
        input  in_bits,
        input  out_ready,
        output out_valid,
        output out_data,
        output out_index,
        output overflow,
        output sync_err
    );
endinterface

// File: rtl/tt_um_collect.sv
// Bit-serial result collector.
//
// Reassembles MAX_OUT_LEN bit-serial result lanes into BIT_WIDTH-bit words.
// Each accepted cycle writes one bit position into every lane's shift word;
// the cycle carrying position BIT_WIDTH-1 completes a frame, which is pushed
// into a small frame FIFO. The reader drains the head frame one lane per
// transfer (lane 0 first) over a valid/ready handshake.
//
// Ports:
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    tt_um_collect_if.slave (input slices, output words, status flags)
//
// The interface instance must be parameterised with the same MAX_OUT_LEN and
// BIT_WIDTH as this module. MAX_OUT_LEN and BIT_WIDTH are limited to 8 by the
// 3-bit in_bit_select / out_index fields.
`timescale 1ns / 1ps

module tt_um_collect #(
    parameter int unsigned MAX_OUT_LEN = 7,
    parameter int unsigned BIT_WIDTH   = 8,
    parameter int unsigned FIFO_DEPTH  = 2
) (
    input logic            clk,
    input logic            rst_n,
    tt_um_collect_if.slave bus
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

    localparam logic [2:0]      LastPos  = 3'(BIT_WIDTH - 1);
    localparam logic [2:0]      LastLane = 3'(MAX_OUT_LEN - 1);
    localparam logic [CntW-1:0] FullCnt  = CntW'(FIFO_DEPTH);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two and at least 2");
    end
    if (MAX_OUT_LEN < 1 || MAX_OUT_LEN > 8 || BIT_WIDTH < 2 || BIT_WIDTH > 8) begin : g_bad_size
        $error("MAX_OUT_LEN must be 1..8 and BIT_WIDTH 2..8");
    end

    typedef logic [BIT_WIDTH-1:0] frame_t [MAX_OUT_LEN];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [2:0]      pos_q, pos_d;          // expected bit position
    frame_t          word_q, word_d;        // per-lane assembly words
    frame_t          fifo_q [FIFO_DEPTH];   // completed frames
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q, count_d;
    logic [2:0]      lane_q, lane_d;        // lane presented by the reader
    logic            overflow_q, overflow_d;
    logic            sync_err_q, sync_err_d;

    logic complete;   // this edge finishes a frame
    logic xfer;       // downstream transfer this edge
    logic pop;        // last lane of the head frame leaves this edge
    logic push;       // completed frame is stored this edge
    logic fifo_full;

    // ------------------------------------------------------------------
    // Assembler
    // ------------------------------------------------------------------
    always_comb begin
        pos_d      = pos_q;
        word_d     = word_q;
        sync_err_d = sync_err_q;
        complete   = 1'b0;

        if (bus.in_valid) begin
            if (bus.in_bit_select == pos_q) begin
                for (int k = 0; k < MAX_OUT_LEN; k++) begin
                    word_d[k][bus.in_bit_select] = bus.in_bits[k];
                end
                if (pos_q == LastPos) begin
                    complete = 1'b1;
                    pos_d    = '0;
                end else begin
                    pos_d = pos_q + 3'd1;
                end
            end else begin
                // Out of sequence: drop the partial frame. A stray position 0
                // is taken as the start of a fresh frame rather than wasted.
                sync_err_d = 1'b1;
                for (int k = 0; k < MAX_OUT_LEN; k++) begin
                    word_d[k] = '0;
                end
                if (bus.in_bit_select == 3'd0) begin
                    for (int k = 0; k < MAX_OUT_LEN; k++) begin
                        word_d[k][0] = bus.in_bits[k];
                    end
                    pos_d = 3'd1;
                end else begin
                    pos_d = '0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame FIFO and reader
    // ------------------------------------------------------------------
    assign fifo_full = (count_q == FullCnt);
    assign xfer      = bus.out_valid && bus.out_ready;
    assign pop       = xfer && (lane_q == LastLane);
    // A pop frees the head slot on the same edge, so a full FIFO still
    // accepts a frame completing together with the last-lane transfer.
    assign push      = complete && (!fifo_full || pop);

    always_comb begin
        lane_d     = lane_q;
        overflow_d = overflow_q;
        count_d    = count_q + CntW'(push) - CntW'(pop);

        if (xfer) begin
            lane_d = pop ? 3'd0 : lane_q + 3'd1;
        end
        if (complete && !push) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            lane_q     <= '0;
            overflow_q <= 1'b0;
            sync_err_q <= 1'b0;
            for (int k = 0; k < MAX_OUT_LEN; k++) begin
                word_q[k] <= '0;
            end
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                for (int k = 0; k < MAX_OUT_LEN; k++) begin
                    fifo_q[i][k] <= '0;
                end
            end
        end else begin
            pos_q      <= pos_d;
            word_q     <= word_d;
            count_q    <= count_d;
            lane_q     <= lane_d;
            overflow_q <= overflow_d;
            sync_err_q <= sync_err_d;
            if (push) begin
                fifo_q[wr_ptr_q] <= word_d;
                wr_ptr_q         <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.out_valid = (count_q != '0);
    // Gated so a drained FIFO does not expose stale frame contents.
    assign bus.out_data  = bus.out_valid ? fifo_q[rd_ptr_q][lane_q] : '0;
    assign bus.out_index = lane_q;
    assign bus.overflow  = overflow_q;
    assign bus.sync_err  = sync_err_q;

endmodule

// File: tb/tb_tt_um_collect.sv
`timescale 1ns / 1ps

module tb_tt_um_collect;

    localparam int unsigned MaxOutLen = 7;
    localparam int unsigned BitWidth  = 8;
    localparam int unsigned FifoDepth = 2;

    logic clk = 1'b0;
    logic rst_n;

    tt_um_collect_if #(.MAX_OUT_LEN(MaxOutLen), .BIT_WIDTH(BitWidth)) bus ();

    tt_um_collect #(
        .MAX_OUT_LEN(MaxOutLen),
        .BIT_WIDTH  (BitWidth),
        .FIFO_DEPTH (FifoDepth)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // exp = {out_valid, out_data, out_index, overflow, sync_err}
    typedef struct {
        logic        in_valid;
        logic [2:0]  sel;
        logic [6:0]  bits;
        logic        ready;
        logic [13:0] exp;
    } vec_t;
    vec_t vecs [17];

    typedef struct {
        logic [2:0] idx;
        logic [7:0] data;
    } word_t;
    word_t expq [$];

    function automatic logic [13:0] outs(input logic v, input logic [7:0] d, input logic [2:0] i,
                                         input logic o, input logic s);
        return {v, d, i, o, s};
    endfunction

    function automatic logic [13:0] dut_outs();
        return {bus.out_valid, bus.out_data, bus.out_index, bus.overflow, bus.sync_err};
    endfunction

    // Distinct, non-trivial word per (frame, lane).
    function automatic logic [7:0] word_of(input int f, input int k);
        return 8'((f * 37 + k * 29 + 3) % 256);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("reset_outs", 32'(dut_outs()), 32'h0);
        rst_n = 1'b1;
        expq.delete();
    endtask

    task automatic drive_pos(input int f, input int p);
        logic [7:0] w;
        bus.in_valid      = 1'b1;
        bus.in_bit_select = 3'(p);
        for (int k = 0; k < MaxOutLen; k++) begin
            w = word_of(f, k);
            bus.in_bits[k] = w[p];
        end
    endtask

    task automatic push_exp(input int f);
        for (int k = 0; k < MaxOutLen; k++) begin
            expq.push_back('{3'(k), word_of(f, k)});
        end
    endtask

    // Sends positions 0..7 of frame f; an idle cycle is inserted before gap_at.
    task automatic send_frame(input int f, input bit keep, input int gap_at);
        for (int p = 0; p < BitWidth; p++) begin
            @(negedge clk);
            if (p == gap_at) begin
                bus.in_valid = 1'b0;
                @(negedge clk);
            end
            drive_pos(f, p);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        if (keep) push_exp(f);
    endtask

    // Drains the DUT against expq; toggle alternates out_ready 1,0,1,0...
    task automatic read_out(input bit toggle, input int exp_words);
        int         n = 0;
        bit         prev_stall = 1'b0;
        bit         done = 1'b0;
        logic [10:0] prev = '0;
        logic       rdy;
        word_t      e;
        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            if (!bus.out_valid) begin
                done = 1'b1;
            end else begin
                if (prev_stall) chk("stall_stable", 32'({bus.out_index, bus.out_data}), 32'(prev));
                rdy = toggle ? (cyc % 2 == 0) : 1'b1;
                bus.out_ready = rdy;
                if (rdy) begin
                    n++;
                    if (expq.size() > 0) begin
                        e = expq.pop_front();
                        chk("rd_index", 32'(bus.out_index), 32'(e.idx));
                        chk("rd_data", 32'(bus.out_data), 32'(e.data));
                    end
                end
                prev       = {bus.out_index, bus.out_data};
                prev_stall = !rdy;
                @(negedge clk);
            end
        end
        chk("readout_done", 32'(done), 32'h1);
        chk("word_count", 32'(n), 32'(exp_words));
        chk("queue_empty", 32'(expq.size()), 32'h0);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid      = 1'b0;
        bus.in_bit_select = '0;
        bus.in_bits       = '0;
        bus.out_ready     = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 chk("reset_initial", 32'(dut_outs()), 32'h0);
        #10 rst_n = 1'b1;

        // ---- single frame, lane 0 = 0x05, continuous ready ----
        vecs[0] = '{1'b0, 3'd0, 7'd0, 1'b1, 14'd0};
        for (int p = 0; p < 8; p++) begin
            vecs[1 + p] = '{1'b1, 3'(p), ((p == 0 || p == 2) ? 7'd1 : 7'd0), 1'b1, 14'd0};
        end
        vecs[9] = '{1'b0, 3'd0, 7'd0, 1'b1, outs(1'b1, 8'h05, 3'd0, 1'b0, 1'b0)};
        for (int i = 1; i < 7; i++) begin
            vecs[9 + i] = '{1'b0, 3'd0, 7'd0, 1'b1, outs(1'b1, 8'h00, 3'(i), 1'b0, 1'b0)};
        end
        vecs[16] = '{1'b0, 3'd0, 7'd0, 1'b1, 14'd0};

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            chk($sformatf("vec%0d", i), 32'(dut_outs()), 32'(vecs[i].exp));
            bus.in_valid      = vecs[i].in_valid;
            bus.in_bit_select = vecs[i].sel;
            bus.in_bits       = vecs[i].bits;
            bus.out_ready     = vecs[i].ready;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;

        // ---- three frames while stalled: third dropped ----
        do_reset();
        send_frame(1, 1'b1, -1);
        send_frame(2, 1'b1, -1);
        send_frame(3, 1'b0, -1);
        chk("ovf_set", 32'(bus.overflow), 32'h1);
        chk("ovf_valid", 32'(bus.out_valid), 32'h1);
        chk("ovf_head", 32'(bus.out_data), 32'(word_of(1, 0)));
        read_out(1'b0, 14);
        chk("ovf_sticky", 32'(bus.overflow), 32'h1);
        chk("ovf_drained", 32'(bus.out_valid), 32'h0);

        // ---- out-of-sequence positions, then a clean frame with a gap ----
        do_reset();
        foreach (vecs[i]) begin end
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            bus.in_valid      = 1'b1;
            bus.in_bit_select = (j == 3) ? 3'd5 : 3'(j);
            bus.in_bits       = 7'h7F;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("sync_err_set", 32'(bus.sync_err), 32'h1);
        chk("sync_no_frame", 32'(bus.out_valid), 32'h0);
        send_frame(20, 1'b1, 3);
        read_out(1'b0, 7);
        chk("sync_err_sticky", 32'(bus.sync_err), 32'h1);
        chk("sync_no_ovf", 32'(bus.overflow), 32'h0);

        // ---- full FIFO, last-lane pop coincides with completing edge ----
        do_reset();
        send_frame(10, 1'b0, -1);
        send_frame(11, 1'b1, -1);
        for (int p = 0; p < BitWidth; p++) begin
            @(negedge clk);
            if (p > 0) begin
                chk("pp_index", 32'(bus.out_index), 32'(p - 1));
                chk("pp_data", 32'(bus.out_data), 32'(word_of(10, p - 1)));
            end
            drive_pos(12, p);
            bus.out_ready = (p != 0);
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        push_exp(12);
        chk("pp_no_ovf", 32'(bus.overflow), 32'h0);
        chk("pp_valid", 32'(bus.out_valid), 32'h1);
        read_out(1'b0, 14);

        // ---- asynchronous reset pulse mid-readout ----
        do_reset();
        send_frame(40, 1'b1, -1);
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #0.5 chk("async_rst_outs", 32'(dut_outs()), 32'h0);
        #0.5 rst_n = 1'b1;
        expq.delete();
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("post_rst_empty", 32'(bus.out_valid), 32'h0);
        send_frame(41, 1'b1, -1);
        read_out(1'b0, 7);

        // ---- ready toggling 1,0,1,0 across a frame ----
        do_reset();
        send_frame(30, 1'b1, -1);
        read_out(1'b1, 7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
